bnn_act_packer: RTL
===================

BNN_ACT_PACKER -- requirements
Module: bnn_act_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 32; width of the packed activation word (supported value: 32 only).
REQ-002 SHALL have port clk, input, 1; rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1; reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1; in_bit/in_last are valid this cycle.
REQ-005 SHALL have port in_bit, input, 1; one neuron sign-activation bit.
REQ-006 SHALL have port in_last, input, 1; the accepted bit closes the current word (partial flush).
REQ-007 SHALL have port in_ready, output, 1; packer accepts a bit this cycle.
REQ-008 SHALL have port out_valid, output, 1; out_data/out_count hold a packed word.
REQ-009 SHALL have port out_ready, input, 1; consumer takes the word this cycle.
REQ-010 SHALL have port out_data, output, WORD_W; packed activations, bit k = k-th accepted bit of the word.
REQ-011 SHALL have port out_count, output, 6; number of valid bits in out_data, 1..32.

Function
REQ-012 SHALL accept an input bit only when in_valid && in_ready (accept).
REQ-013 SHALL place accepted bits LSB-first into an assembly register at the index held by a 5-bit bit counter, then increment the counter.
REQ-014 SHALL complete a word on the accept that either has the counter at 31 or has in_last=1, whichever comes first.
REQ-015 SHALL, on completion, push {word, count} into a 2-entry output FIFO, zero the unused upper bits, and clear the assembly register and counter in that same edge.
REQ-016 SHALL present a pushed word with out_valid=1 on the cycle after the completing accept (latency 1).
REQ-017 SHALL pop the FIFO head on out_valid && out_ready; out_data/out_count SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 SHALL drive in_ready = !(FIFO holds 2 entries), from registered state only, with no combinational path from out_ready.
REQ-019 SHALL keep the FIFO occupancy unchanged when a push and a pop occur in the same cycle with 1 entry held.
REQ-020 SHALL ignore in_bit and in_last when in_valid=0.
REQ-021 SHALL, with in_last=1 and the counter at 31 on the same accept, produce exactly one word with out_count=32.
REQ-022 SHALL produce no word, and SHALL NOT emit an empty word, when no bits are pending.

Reset
REQ-023 SHALL, while rst_n=1, clear the assembly register, the counter and the FIFO, and drive out_valid=0, out_data=0, out_count=0 and in_ready=1.
REQ-024 SHALL discard any partial word and any FIFO contents when reset is asserted mid-operation; no word SHALL be emitted from pre-reset bits.

Configuration
REQ-025 SHALL, when BNN_PACK_POPCNT_EN is defined, add output out_popcnt, 6 bits, equal to the number of ones in out_data. The value is registered with the FIFO entry, is 0 in reset, and has the same latency and hold rules as out_data.
REQ-026 SHALL, when BNN_PACK_POPCNT_EN is undefined, omit the port and all popcount logic.

Structure
REQ-027 SHALL take WORD_W, the counter width (5), the count width (6) and the FIFO depth (2) from shared package bnn_pkg.
REQ-028 SHALL implement the output FIFO as sub-module bnn_pack_fifo (2-entry, registered full/empty); the packing logic stays in bnn_act_packer.

Verification
REQ-029 SHALL cover a full word: 32 accepts of alternating bits 1,0,... with out_ready=1 -> one word out_data=0x55555555, out_count=32, out_valid one cycle after the 32nd accept.
REQ-030 SHALL cover a partial flush: bits 1,1,0,1 with in_last on the 4th -> out_data=0x0000000B, out_count=4 (out_popcnt=3 if enabled).
REQ-031 SHALL cover backpressure: out_ready=0 and 3 flushed words of one '1' bit each -> in_ready drops after 2 words, the third bit waits, and releasing out_ready yields 3 words of 0x00000001 in order with no loss.
REQ-032 SHALL cover a simultaneous push and pop: 1 entry held, out_ready=1 and a completing accept in the same cycle -> occupancy stays 1 and in_ready stays 1.
REQ-033 SHALL cover reset mid-word: 10 bits accepted, then rst_n pulsed -> out_valid=0; the next 32 bits form a clean word with out_count=32.
REQ-034 SHALL cover the in_last edge case: in_last on the 32nd bit -> exactly one word with out_count=32, followed by no empty word.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared constants for the BNN activation packer: word width, bit-counter width,
// count width and output FIFO depth, plus a popcount helper.
package bnn_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned COUNT_W    = 6;
  localparam int unsigned FIFO_DEPTH = 2;

  // Number of ones in a packed activation word.
  function automatic logic [COUNT_W-1:0] popcount(input logic [WORD_W-1:0] w);
    logic [COUNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      sum = sum + COUNT_W'(w[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/bnn_pack_fifo.sv
// Two-entry output FIFO for packed words. Full and empty are kept as registers so
// that the packer's in_ready never depends combinationally on the consumer.
// Head data reads as zero while empty.
module bnn_pack_fifo
  import bnn_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_W + COUNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              do_push, do_pop;

  // Pointer and flag next-state; flag update assumes a depth of two.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    empty_d  = empty_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10: begin
        empty_d = 1'b0;
        full_d  = !empty_q;  // one entry held before the push
      end
      2'b01: begin
        full_d  = 1'b0;
        empty_d = !full_q;   // one entry held before the pop
      end
      default: ;             // idle, or push+pop keeps occupancy
    endcase
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Entry storage; cleared in reset so nothing from before reset survives.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Head and status outputs.
  always_comb begin
    pop_data = empty_q ? '0 : mem_q[rd_ptr_q];
    full     = full_q;
    empty    = empty_q;
  end

endmodule

// File: rtl/bnn_act_packer.sv
// Packs a stream of sign-activation bits LSB-first into 32-bit words. A word
// closes after 32 bits or on an accepted in_last, and is queued in a two-entry
// FIFO for the consumer. Optional popcount output: define BNN_PACK_POPCNT_EN.
module bnn_act_packer #(
  parameter int unsigned WORD_W = bnn_pkg::WORD_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic                        in_bit,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic [bnn_pkg::COUNT_W-1:0] out_count
`ifdef BNN_PACK_POPCNT_EN
  ,
  output logic [bnn_pkg::COUNT_W-1:0] out_popcnt
`endif
);

  import bnn_pkg::*;

`ifdef BNN_PACK_POPCNT_EN
  localparam int unsigned ENTRY_W = WORD_W + 2 * COUNT_W;
`else
  localparam int unsigned ENTRY_W = WORD_W + COUNT_W;
`endif

  logic [WORD_W-1:0]  asm_q, asm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  word_nxt;
  logic [WORD_W-1:0]  keep_mask;
  logic [WORD_W-1:0]  push_word;
  logic [COUNT_W-1:0] push_count;
  logic               accept;
  logic               complete;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Assembly next-state: insert the accepted bit and decide whether the word closes.
  always_comb begin
    accept     = in_valid && in_ready;
    word_nxt   = asm_q;
    word_nxt[cnt_q] = in_bit;
    complete   = accept && (in_last || (cnt_q == CNT_W'(WORD_W - 1)));
    push_count = COUNT_W'(cnt_q) + COUNT_W'(1);
    // Shift by 32 yields zero, so a full word keeps every bit.
    keep_mask  = ~({WORD_W{1'b1}} << push_count);
    push_word  = word_nxt & keep_mask;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    if (accept) begin
      if (complete) begin
        asm_d = '0;
        cnt_d = '0;
      end else begin
        asm_d = word_nxt;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Assembly register and bit counter.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

  // FIFO entry layout: {popcount (optional), count, word}.
  always_comb begin
`ifdef BNN_PACK_POPCNT_EN
    push_entry = {popcount(push_word), push_count, push_word};
`else
    push_entry = {push_count, push_word};
`endif
  end

  bnn_pack_fifo #(
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (complete),
    .push_data (push_entry),
    .pop       (out_ready),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Handshake and head outputs, all from registered FIFO state.
  always_comb begin
    in_ready  = !fifo_full;
    out_valid = !fifo_empty;
`ifdef BNN_PACK_POPCNT_EN
    {out_popcnt, out_count, out_data} = head_entry;
`else
    {out_count, out_data} = head_entry;
`endif
  end

endmodule
